// File: rtl/vector_ctrl_pipeline.sv
// Execute/Memory/Writeback control registers for the vector CPU: carries decoded
// control bits, inserts load-use bubbles, applies branch flushes and memory holds.
module vector_ctrl_pipeline #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      validD,
    input  logic                      useScalarAluD,
    input  logic                      isScalarOutputD,
    input  logic                      isScalarReg1D,
    input  logic                      isScalarReg2D,
    input  logic                      useInmediateD,
    input  logic [3:0]                aluControlD,
    input  logic                      writeToMemoryEnableMD,
    input  logic                      outFlagMD,
    input  logic                      resultSelectorWBD,
    input  logic                      writeEnableScalarWBD,
    input  logic                      writeEnableVectorWBD,
    input  logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic                      flushE,
    input  logic                      memBusy,
    output logic                      validE,
    output logic                      useScalarAluE,
    output logic                      isScalarOutputE,
    output logic                      isScalarReg1E,
    output logic                      isScalarReg2E,
    output logic                      useInmediateE,
    output logic [3:0]                aluControlE,
    output logic [REG_ADDR_WIDTH-1:0] rdE,
    output logic                      validM,
    output logic                      writeToMemoryEnableM,
    output logic                      outFlagM,
    output logic [REG_ADDR_WIDTH-1:0] rdM,
    output logic                      validW,
    output logic                      resultSelectorW,
    output logic                      writeEnableScalarW,
    output logic                      writeEnableVectorW,
    output logic [REG_ADDR_WIDTH-1:0] rdW,
    output logic                      stallF,
    output logic                      stallD,
    output logic [CNT_WIDTH-1:0]      stallCount
);

    typedef struct packed {
        logic                      valid;
        logic                      useScalarAlu;
        logic                      isScalarOutput;
        logic                      isScalarReg1;
        logic                      isScalarReg2;
        logic                      useInmediate;
        logic [3:0]                aluControl;
        logic                      writeToMemoryEnable;
        logic                      outFlag;
        logic                      resultSelector;
        logic                      writeEnableScalar;
        logic                      writeEnableVector;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } eStage_t;

    typedef struct packed {
        logic                      valid;
        logic                      writeToMemoryEnable;
        logic                      outFlag;
        logic                      resultSelector;
        logic                      writeEnableScalar;
        logic                      writeEnableVector;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } mStage_t;

    typedef struct packed {
        logic                      valid;
        logic                      resultSelector;
        logic                      writeEnableScalar;
        logic                      writeEnableVector;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } wStage_t;

    eStage_t eReg, eNext;
    mStage_t mReg, mNext;
    wStage_t wReg, wNext;
    logic    loadUse;
    logic    stall;
    logic [CNT_WIDTH-1:0] stallCnt;

    // A vector load in E whose result a vector source of D needs; rs2 is
    // irrelevant when D takes an immediate instead.
    always_comb begin
        loadUse = eReg.valid & eReg.resultSelector & eReg.writeEnableVector & validD &
                  (((eReg.rd == rs1D) & ~isScalarReg1D) |
                   ((eReg.rd == rs2D) & ~isScalarReg2D & ~useInmediateD));
    end

    assign stall = memBusy | (loadUse & ~flushE);

    always_comb begin
        eNext = '0;
        if (validD && !flushE && !loadUse) begin
            eNext.valid               = 1'b1;
            eNext.useScalarAlu        = useScalarAluD;
            eNext.isScalarOutput      = isScalarOutputD;
            eNext.isScalarReg1        = isScalarReg1D;
            eNext.isScalarReg2        = isScalarReg2D;
            eNext.useInmediate        = useInmediateD;
            eNext.aluControl          = aluControlD;
            eNext.writeToMemoryEnable = writeToMemoryEnableMD;
            eNext.outFlag             = outFlagMD;
            eNext.resultSelector      = resultSelectorWBD;
            eNext.writeEnableScalar   = writeEnableScalarWBD;
            eNext.writeEnableVector   = writeEnableVectorWBD;
            eNext.rd                  = rdD;
        end
    end

    always_comb begin
        mNext                     = '0;
        mNext.valid               = eReg.valid;
        mNext.writeToMemoryEnable = eReg.writeToMemoryEnable;
        mNext.outFlag             = eReg.outFlag;
        mNext.resultSelector      = eReg.resultSelector;
        mNext.writeEnableScalar   = eReg.writeEnableScalar;
        mNext.writeEnableVector   = eReg.writeEnableVector;
        mNext.rd                  = eReg.rd;
    end

    always_comb begin
        wNext                   = '0;
        wNext.valid             = mReg.valid;
        wNext.resultSelector    = mReg.resultSelector;
        wNext.writeEnableScalar = mReg.writeEnableScalar;
        wNext.writeEnableVector = mReg.writeEnableVector;
        wNext.rd                = mReg.rd;
    end

    // memBusy freezes every stage; a pending flush waits until it drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eReg <= '0;
            mReg <= '0;
            wReg <= '0;
        end else if (!memBusy) begin
            eReg <= eNext;
            mReg <= mNext;
            wReg <= wNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != {CNT_WIDTH{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign validE               = eReg.valid;
    assign useScalarAluE        = eReg.useScalarAlu;
    assign isScalarOutputE      = eReg.isScalarOutput;
    assign isScalarReg1E        = eReg.isScalarReg1;
    assign isScalarReg2E        = eReg.isScalarReg2;
    assign useInmediateE        = eReg.useInmediate;
    assign aluControlE          = eReg.aluControl;
    assign rdE                  = eReg.rd;
    assign validM               = mReg.valid;
    assign writeToMemoryEnableM = mReg.writeToMemoryEnable;
    assign outFlagM             = mReg.outFlag;
    assign rdM                  = mReg.rd;
    assign validW               = wReg.valid;
    assign resultSelectorW      = wReg.resultSelector;
    assign writeEnableScalarW   = wReg.writeEnableScalar;
    assign writeEnableVectorW   = wReg.writeEnableVector;
    assign rdW                  = wReg.rd;
    assign stallF               = stall;
    assign stallD               = stall;
    assign stallCount           = stallCnt;

endmodule

// File: tb/tb_vector_ctrl_pipeline.sv
// Bench for vector_ctrl_pipeline: an instruction-level pipe model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vector_ctrl_pipeline;
    localparam int RAW  = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic           valid;
        logic           usa;
        logic           iso;
        logic           isr1;
        logic           isr2;
        logic           imm;
        logic [3:0]     alu;
        logic           wme;
        logic           oflag;
        logic           rsel;
        logic           wes;
        logic           wev;
        logic [RAW-1:0] rd;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n;
    instr_t dIn;
    logic flushE, memBusy;

    logic validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E, useInmediateE;
    logic [3:0] aluControlE;
    logic [RAW-1:0] rdE, rdM, rdW;
    logic validM, writeToMemoryEnableM, outFlagM;
    logic validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW;
    logic stallF, stallD;
    logic [CW-1:0] stallCount;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    vector_ctrl_pipeline #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .validD(dIn.valid), .useScalarAluD(dIn.usa), .isScalarOutputD(dIn.iso),
        .isScalarReg1D(dIn.isr1), .isScalarReg2D(dIn.isr2), .useInmediateD(dIn.imm),
        .aluControlD(dIn.alu), .writeToMemoryEnableMD(dIn.wme), .outFlagMD(dIn.oflag),
        .resultSelectorWBD(dIn.rsel), .writeEnableScalarWBD(dIn.wes),
        .writeEnableVectorWBD(dIn.wev), .rdD(dIn.rd), .rs1D(dIn.rs1), .rs2D(dIn.rs2),
        .flushE(flushE), .memBusy(memBusy),
        .validE(validE), .useScalarAluE(useScalarAluE), .isScalarOutputE(isScalarOutputE),
        .isScalarReg1E(isScalarReg1E), .isScalarReg2E(isScalarReg2E),
        .useInmediateE(useInmediateE), .aluControlE(aluControlE), .rdE(rdE),
        .validM(validM), .writeToMemoryEnableM(writeToMemoryEnableM), .outFlagM(outFlagM),
        .rdM(rdM), .validW(validW), .resultSelectorW(resultSelectorW),
        .writeEnableScalarW(writeEnableScalarW), .writeEnableVectorW(writeEnableVectorW),
        .rdW(rdW), .stallF(stallF), .stallD(stallD), .stallCount(stallCount)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: whole instructions move through three slots; outputs are projections.
    instr_t mE, mM, mW;
    int mCnt;

    function automatic logic hazard(input instr_t e, input instr_t d);
        return e.valid && e.rsel && e.wev && d.valid &&
               ((e.rd == d.rs1 && !d.isr1) || (e.rd == d.rs2 && !d.isr2 && !d.imm));
    endfunction

    function automatic logic modelStall();
        return memBusy || (hazard(mE, dIn) && !flushE);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mE <= '0; mM <= '0; mW <= '0; mCnt <= 0;
        end else begin
            if (modelStall() && mCnt < MAXC) mCnt <= mCnt + 1;
            if (!memBusy) begin
                mW <= mM;
                mM <= mE;
                if (flushE || hazard(mE, dIn) || !dIn.valid) mE <= '0;
                else mE <= dIn;
            end
        end
    end

    always @(negedge clk) begin
        check("Estage", {18'd0, validE, useScalarAluE, isScalarOutputE, isScalarReg1E,
                         isScalarReg2E, useInmediateE, aluControlE, rdE},
              {18'd0, mE.valid, mE.usa, mE.iso, mE.isr1, mE.isr2, mE.imm, mE.alu, mE.rd});
        check("Mstage", {25'd0, validM, writeToMemoryEnableM, outFlagM, rdM},
              {25'd0, mM.valid, mM.wme, mM.oflag, mM.rd});
        check("Wstage", {24'd0, validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW, rdW},
              {24'd0, mW.valid, mW.rsel, mW.wes, mW.wev, mW.rd});
        check("stall", {30'd0, stallF, stallD}, {30'd0, modelStall(), modelStall()});
        check("stallCount", {28'd0, stallCount}, mCnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic rsel, input logic wev, input logic wes,
                                  input logic [3:0] alu, input logic [RAW-1:0] rd,
                                  input logic [RAW-1:0] rs1, input logic isr1,
                                  input logic [RAW-1:0] rs2, input logic isr2);
        instr_t t = '0;
        t.valid = 1'b1; t.rsel = rsel; t.wev = wev; t.wes = wes; t.alu = alu;
        t.rd = rd; t.rs1 = rs1; t.isr1 = isr1; t.rs2 = rs2; t.isr2 = isr2;
        t.usa = wes; t.wme = (alu == 4'd9); t.oflag = alu[0];
        return t;
    endfunction

    instr_t nop = '0;
    instr_t vldr, addI;
    int cnt0;

    initial begin
        rst_n = 1'b0; dIn = '0; flushE = 1'b0; memBusy = 1'b0;
        vldr = mk(1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 4'd1, 1'b1, 4'd2, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        check("resetValidE", {31'd0, validE}, 0);
        check("resetCount", {28'd0, stallCount}, 0);

        // straight flow
        addI = mk(1'b0, 1'b0, 1'b1, 4'b0100, 4'd3, 4'd1, 1'b1, 4'd2, 1'b1);
        dIn = addI; tick();
        check("flowE", {27'd0, validE, aluControlE}, {27'd0, 1'b1, 4'd4});
        dIn = nop; tick();
        check("flowM", {31'd0, validM}, 1);
        tick();
        check("flowW", {27'd0, writeEnableScalarW, rdW}, {27'd0, 1'b1, 4'd3});

        // load-use: one bubble, dependent enters E next edge
        dIn = vldr; tick();
        dIn = mk(1'b0, 1'b1, 1'b0, 4'd1, 4'd6, 4'd5, 1'b0, 4'd7, 1'b0);
        #1 check("luStall", {31'd0, stallD}, 1);
        tick();
        check("luBubble", {31'd0, validE}, 0);
        check("luCount", {28'd0, stallCount}, 1);
        check("luStallDrop", {31'd0, stallD}, 0);
        tick();
        check("luVaddE", {27'd0, validE, rdE}, {27'd0, 1'b1, 4'd6});
        dIn = nop; tick();

        // scalar rs2 operand must not raise a hazard
        dIn = vldr; tick();
        dIn = mk(1'b0, 1'b1, 1'b0, 4'd2, 4'd8, 4'd2, 1'b0, 4'd5, 1'b1);
        #1 check("noFalseHaz", {31'd0, stallD}, 0);
        tick();
        check("noFalseE", {27'd0, validE, rdE}, {27'd0, 1'b1, 4'd8});
        dIn = nop; tick();

        // flush beats load-use
        dIn = vldr; tick();
        dIn = mk(1'b0, 1'b1, 1'b0, 4'd1, 4'd6, 4'd5, 1'b0, 4'd7, 1'b0);
        flushE = 1'b1;
        #1 check("flushNoStall", {31'd0, stallD}, 0);
        tick();
        check("flushBubble", {31'd0, validE}, 0);
        check("flushCount", {28'd0, stallCount}, 1);
        flushE = 1'b0; dIn = nop; tick();

        // memBusy holds everything; flush deferred
        dIn = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd9, 4'd0, 1'b1, 4'd0, 1'b1); tick();
        dIn = mk(1'b0, 1'b0, 1'b1, 4'd9, 4'd10, 4'd0, 1'b1, 4'd0, 1'b1); tick();
        cnt0 = stallCount;
        dIn = mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd11, 4'd0, 1'b1, 4'd0, 1'b1);
        memBusy = 1'b1; flushE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busyHoldE", {27'd0, validE, rdE}, {27'd0, 1'b1, 4'd10});
            check("busyHoldM", {27'd0, validM, rdM}, {27'd0, 1'b1, 4'd9});
        end
        check("busyCount", {28'd0, stallCount}, 4);
        memBusy = 1'b0;
        tick();
        check("busyFlushE", {31'd0, validE}, 0);
        check("busyAdvM", {28'd0, rdM}, 10);
        flushE = 1'b0; dIn = nop;

        // async reset mid-cycle
        dIn = addI; tick();
        #1 rst_n = 1'b0;
        #1 check("asyncRstE", {31'd0, validE}, 0);
        check("asyncRstCnt", {28'd0, stallCount}, 0);
        #1 rst_n = 1'b1;
        dIn = nop; tick();

        // saturation of the stall counter
        memBusy = 1'b1;
        repeat (MAXC + 5) tick();
        check("satCount", {28'd0, stallCount}, MAXC);
        memBusy = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/vector_ctrl_pipeline.md
# vector_ctrl_pipeline

Carries the decoded control bundle from the decode stage through the Execute, Memory and Writeback pipeline registers of the vector CPU. It is the consumer end of the decoder's control outputs. It detects the vector load-use hazard, inserts bubbles, applies branch flushes and holds the whole pipeline while the vector memory is busy. It also exports stall requests for fetch/decode and a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- REG_ADDR_WIDTH, 4, width of register specifiers
- CNT_WIDTH, 16, width of stall-cycle counter

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- validD  input  1  D-stage holds a real instruction
- useScalarAluD, isScalarOutputD, isScalarReg1D, isScalarReg2D, useInmediateD  input  1 each  E-stage controls from decoder
- aluControlD  input  4  ALU operation
- writeToMemoryEnableMD, outFlagMD  input  1 each  M-stage controls
- resultSelectorWBD, writeEnableScalarWBD, writeEnableVectorWBD  input  1 each  WB-stage controls
- rdD, rs1D, rs2D  input  REG_ADDR_WIDTH each  destination and sources of D instruction
- flushE  input  1  branch/jump taken in E; kill instruction in D
- memBusy  input  1  vector memory multi-cycle access in progress
- E outputs: validE, useScalarAluE, isScalarOutputE, isScalarReg1E, isScalarReg2E, useInmediateE (1 each), aluControlE (4), rdE (REG_ADDR_WIDTH)
- M outputs: validM, writeToMemoryEnableM, outFlagM (1 each), rdM (REG_ADDR_WIDTH)
- WB outputs: validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW (1 each), rdW (REG_ADDR_WIDTH)
- stallF, stallD  output  1 each  hold fetch PC / D register
- stallCount  output  CNT_WIDTH  saturating count of cycles with stallD=1

## Operation
- Three control registers, E, M and W. Each holds a valid bit, rd and its stage's controls. Later-stage controls travel with the instruction: M-group and W-group bits are captured at D→E and forwarded unchanged.
- Bubble: valid=0, all controls and rd = 0. Write/memory enables are therefore never asserted for a bubble.
- loadUse (combinational) = validE & resultSelectorWE & writeEnableVectorWE & validD & ((rdE==rs1D & ~isScalarReg1D) | (rdE==rs2D & ~isScalarReg2D & ~useInmediateD)). resultSelectorWE and writeEnableVectorWE are the W-group bits held in E.
- Per edge, priority high to low:
  1. memBusy=1: E, M and W all hold. stallF = stallD = 1. flushE is ignored; the producer holds flushE until memBusy falls.
  2. flushE=1: bubble into E; E→M and M→W advance. stallF = stallD = 0, even if loadUse.
  3. loadUse=1: bubble into E; M and W advance. stallF = stallD = 1.
  4. Otherwise: D→E, E→M, M→W.
- stallF = stallD = memBusy | (loadUse & ~flushE). Combinational, same cycle.
- stallCount increments by 1 on each edge where stallD=1 and saturates at all-ones, with no wrap.
- validD=0 with no stall: a bubble enters E.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-stall): all stage registers become bubbles. stallCount = 0. Outputs are 0 immediately, without waiting for a clock. Deassertion is synchronous to the first following edge.
- Latency: a D-stage bundle appears on the E outputs 1 edge after capture, on M after 2 and on W after 3, each delay extended by hold cycles.
- Load-use costs exactly 1 bubble. On the following cycle the load has moved to M, loadUse drops and the dependent instruction enters E.
- stallF/stallD and loadUse are purely combinational from the current inputs and the E register. No registered delay.
- A memBusy pulse of N cycles freezes all outputs for N edges and adds N to stallCount.

## Test plan
- Reset: drive a nonzero pipeline, pulse rst_n low between edges -> all outputs 0 and stallCount=0 before the next edge.
- Straight flow: ADD (writeEnableScalarWBD=1, aluControlD=4'b0100, rd=3) -> validE with aluControlE=4 at edge 1, validM at edge 2, writeEnableScalarW=1 and rdW=3 at edge 3.
- Load-use: VLDR rd=5 followed by VADD rs1=5 (isScalarReg1D=0) -> stallD=1 for one cycle, one bubble in E, VADD reaches E one edge later, stallCount=1.
- No false hazard: VLDR rd=5 then VSADD rs2=5 with isScalarReg2D=1 -> stallD stays 0.
- Flush vs hazard: flushE=1 while loadUse=1 -> stallD=0, bubble in E, stallCount unchanged.
- memBusy held 3 cycles with flushE=1 -> all stage outputs frozen, stallCount += 3. Flush is applied on the first edge after memBusy falls.
